pa_clic_int_sel: RTL and testbench

- Downstream stage of the CLIC arbiter.
- Registers the arbitration winner and filters it against the interrupt-level threshold.
- Presents a stable, qualified interrupt request to the core with a valid/ack handshake.
- After the core acknowledges, issues a one-cycle claim pulse back to the interrupt kids so edge-triggered pending bits clear.

---
 rtl/pa_clic_int_sel.sv | 155 +++++++++++++++
 tb/tb_pa_clic_int_sel.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pa_clic_int_sel.sv
// pa_clic_int_sel: downstream stage of the CLIC arbiter.
//
// Registers the arbitration winner, filters it against the level threshold
// and presents a stable request to the core with a valid/ack handshake.
// After the core acknowledges, it issues a one-cycle claim pulse back to the
// interrupt kids so that edge-triggered pending bits clear.
//
// Ports:
//   clic_clk              block clock
//   cpurst_b              synchronous active-low reset
//   arb_ctrl_int_req_raw  any interrupt requesting
//   arb_ctrl_int_id/il/hv/mode  arbitration winner attributes
//   ctrl_int_th           level threshold (max of mintthresh / current mil)
//   cpu_clic_int_ack      core accepts the presented interrupt
//   clic_cpu_int_vld/id/il/hv/mode  request presented to the core
//   clic_kid_claim_vld/id one-cycle claim pulse and claimed id
//
// Optional build macro:
//   CLIC_PREEMPT_UPDATE_EN  when defined, a qualified winner with a different
//                           id and strictly higher level replaces the pending
//                           request in place without dropping vld.

module pa_clic_int_sel #(
    parameter int unsigned ID_WIDTH = 12,
    parameter int unsigned IL_WIDTH = 8
) (
    input  logic                clic_clk,
    input  logic                cpurst_b,
    input  logic                arb_ctrl_int_req_raw,
    input  logic [ID_WIDTH-1:0] arb_ctrl_int_id,
    input  logic [IL_WIDTH-1:0] arb_ctrl_int_il,
    input  logic                arb_ctrl_int_hv,
    input  logic                arb_ctrl_int_mode,
    input  logic [IL_WIDTH-1:0] ctrl_int_th,
    input  logic                cpu_clic_int_ack,
    output logic                clic_cpu_int_vld,
    output logic [ID_WIDTH-1:0] clic_cpu_int_id,
    output logic [IL_WIDTH-1:0] clic_cpu_int_il,
    output logic                clic_cpu_int_hv,
    output logic                clic_cpu_int_mode,
    output logic                clic_kid_claim_vld,
    output logic [ID_WIDTH-1:0] clic_kid_claim_id
);

    typedef enum logic [1:0] {StIdle, StPend, StClaim} state_e;

    state_e                state_q, state_d;
    logic                  vld_q, vld_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [IL_WIDTH-1:0]   il_q, il_d;
    logic                  hv_q, hv_d;
    logic                  mode_q, mode_d;
    logic                  claim_vld_q, claim_vld_d;
    logic [ID_WIDTH-1:0]   claim_id_q, claim_id_d;

    logic qual;
    logic id_diff;

    // A level equal to the threshold does not qualify.
    assign qual    = arb_ctrl_int_req_raw & (arb_ctrl_int_il > ctrl_int_th);
    assign id_diff = (arb_ctrl_int_id != id_q);

    always_comb begin
        state_d     = state_q;
        vld_d       = 1'b0;
        id_d        = id_q;
        il_d        = il_q;
        hv_d        = hv_q;
        mode_d      = mode_q;
        claim_vld_d = 1'b0;
        claim_id_d  = claim_id_q;

        unique case (state_q)
            StIdle: begin
                if (qual) begin
                    state_d = StPend;
                    vld_d   = 1'b1;
                    id_d    = arb_ctrl_int_id;
                    il_d    = arb_ctrl_int_il;
                    hv_d    = arb_ctrl_int_hv;
                    mode_d  = arb_ctrl_int_mode;
                end
            end
            StPend: begin
                vld_d = 1'b1;
                if (cpu_clic_int_ack) begin
                    // Honoured even if the request dropped in the same cycle.
                    state_d     = StClaim;
                    vld_d       = 1'b0;
                    claim_vld_d = 1'b1;
                    claim_id_d  = id_q;
                end else if (!qual) begin
                    state_d = StIdle;
                    vld_d   = 1'b0;
                end else if (id_diff) begin
                    if (arb_ctrl_int_il < il_q) begin
                        // A lower winner means the held source went away.
                        state_d = StIdle;
                        vld_d   = 1'b0;
                    end else if (arb_ctrl_int_il > il_q) begin
`ifdef CLIC_PREEMPT_UPDATE_EN
                        id_d   = arb_ctrl_int_id;
                        il_d   = arb_ctrl_int_il;
                        hv_d   = arb_ctrl_int_hv;
                        mode_d = arb_ctrl_int_mode;
`else
                        // Keep the held request until ack or withdraw.
                        state_d = StPend;
`endif
                    end
                end else begin
                    hv_d   = arb_ctrl_int_hv;
                    mode_d = arb_ctrl_int_mode;
                end
            end
            StClaim: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clic_clk) begin
        if (!cpurst_b) begin
            state_q     <= StIdle;
            vld_q       <= 1'b0;
            id_q        <= '0;
            il_q        <= '0;
            hv_q        <= 1'b0;
            mode_q      <= 1'b0;
            claim_vld_q <= 1'b0;
            claim_id_q  <= '0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            id_q        <= id_d;
            il_q        <= il_d;
            hv_q        <= hv_d;
            mode_q      <= mode_d;
            claim_vld_q <= claim_vld_d;
            claim_id_q  <= claim_id_d;
        end
    end

    assign clic_cpu_int_vld   = vld_q;
    assign clic_cpu_int_id    = id_q;
    assign clic_cpu_int_il    = il_q;
    assign clic_cpu_int_hv    = hv_q;
    assign clic_cpu_int_mode  = mode_q;
    assign clic_kid_claim_vld = claim_vld_q;
    assign clic_kid_claim_id  = claim_id_q;

endmodule

// File: tb/tb_pa_clic_int_sel.sv
// Directed testbench for pa_clic_int_sel. Inputs change 1 time unit after a
// rising edge; outputs are sampled there too, i.e. they show the cycle that
// the preceding edge produced.
module tb_pa_clic_int_sel;

    localparam int unsigned ID_WIDTH = 12;
    localparam int unsigned IL_WIDTH = 8;

    logic                clic_clk;
    logic                cpurst_b;
    logic                req_raw;
    logic [ID_WIDTH-1:0] arb_id;
    logic [IL_WIDTH-1:0] arb_il;
    logic                arb_hv;
    logic                arb_mode;
    logic [IL_WIDTH-1:0] th;
    logic                ack;
    logic                vld;
    logic [ID_WIDTH-1:0] out_id;
    logic [IL_WIDTH-1:0] out_il;
    logic                out_hv;
    logic                out_mode;
    logic                claim_vld;
    logic [ID_WIDTH-1:0] claim_id;

    int n_checks = 0;
    int n_errors = 0;

    pa_clic_int_sel #(
        .ID_WIDTH(ID_WIDTH),
        .IL_WIDTH(IL_WIDTH)
    ) dut (
        .clic_clk            (clic_clk),
        .cpurst_b            (cpurst_b),
        .arb_ctrl_int_req_raw(req_raw),
        .arb_ctrl_int_id     (arb_id),
        .arb_ctrl_int_il     (arb_il),
        .arb_ctrl_int_hv     (arb_hv),
        .arb_ctrl_int_mode   (arb_mode),
        .ctrl_int_th         (th),
        .cpu_clic_int_ack    (ack),
        .clic_cpu_int_vld    (vld),
        .clic_cpu_int_id     (out_id),
        .clic_cpu_int_il     (out_il),
        .clic_cpu_int_hv     (out_hv),
        .clic_cpu_int_mode   (out_mode),
        .clic_kid_claim_vld  (claim_vld),
        .clic_kid_claim_id   (claim_id)
    );

    initial clic_clk = 1'b0;
    always #5 clic_clk = ~clic_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clic_clk);
        #1;
    endtask

    task automatic set_win(input logic r, input int id, input int il);
        req_raw = r;
        arb_id  = ID_WIDTH'(id);
        arb_il  = IL_WIDTH'(il);
    endtask

    initial begin
        cpurst_b = 1'b0;
        set_win(1'b0, 0, 0);
        arb_hv   = 1'b0;
        arb_mode = 1'b0;
        th       = '0;
        ack      = 1'b0;
        step();
        step();
        check("rst_vld", 32'(vld), 32'd0);
        check("rst_id", 32'(out_id), 32'd0);
        check("rst_il", 32'(out_il), 32'd0);
        check("rst_hv_mode", 32'({out_hv, out_mode}), 32'd0);
        check("rst_claim", 32'({claim_vld, claim_id}), 32'd0);

        // Basic handshake: qual at cycle 0, ack at cycle 3.
        cpurst_b = 1'b1;
        set_win(1'b1, 5, 8'h3F);
        arb_hv   = 1'b1;
        arb_mode = 1'b1;
        step();
        check("hs_c1_vld", 32'(vld), 32'd1);
        check("hs_c1_id", 32'(out_id), 32'd5);
        check("hs_c1_il", 32'(out_il), 32'h3F);
        check("hs_c1_hv_mode", 32'({out_hv, out_mode}), 32'd3);
        check("hs_c1_claim", 32'(claim_vld), 32'd0);
        step();
        check("hs_c2_vld", 32'(vld), 32'd1);
        step();
        check("hs_c3_vld", 32'(vld), 32'd1);
        ack = 1'b1;
        step();
        check("hs_c4_vld", 32'(vld), 32'd0);
        check("hs_c4_claim", 32'(claim_vld), 32'd1);
        check("hs_c4_claim_id", 32'(claim_id), 32'd5);
        ack = 1'b0;
        set_win(1'b0, 5, 8'h3F);
        step();
        check("hs_c5_claim", 32'(claim_vld), 32'd0);
        check("hs_c5_vld", 32'(vld), 32'd0);

        // Ack while nothing is presented is ignored.
        ack = 1'b1;
        step();
        check("idle_ack_claim", 32'(claim_vld), 32'd0);
        check("idle_ack_vld", 32'(vld), 32'd0);
        ack = 1'b0;

        // Threshold boundary: equal level does not qualify.
        th = 8'h3F;
        set_win(1'b1, 3, 8'h3F);
        step();
        check("th_eq_vld_a", 32'(vld), 32'd0);
        step();
        check("th_eq_vld_b", 32'(vld), 32'd0);
        th = 8'h3E;
        step();
        check("th_below_vld", 32'(vld), 32'd1);
        check("th_below_id", 32'(out_id), 32'd3);
        set_win(1'b0, 3, 8'h3F);
        step();
        check("th_drop_vld", 32'(vld), 32'd0);
        check("th_drop_claim", 32'(claim_vld), 32'd0);

        // Withdraw by req_raw dropping.
        th = 8'h00;
        set_win(1'b1, 7, 8'h40);
        step();
        check("wd_vld", 32'(vld), 32'd1);
        check("wd_id", 32'(out_id), 32'd7);
        set_win(1'b0, 7, 8'h40);
        step();
        check("wd_drop_vld", 32'(vld), 32'd0);
        check("wd_drop_claim", 32'(claim_vld), 32'd0);

        // Withdraw by a lower-level winner with another id.
        set_win(1'b1, 7, 8'h40);
        step();
        check("wd2_vld", 32'(vld), 32'd1);
        set_win(1'b1, 2, 8'h10);
        step();
        check("wd2_low_vld", 32'(vld), 32'd0);
        check("wd2_low_claim", 32'(claim_vld), 32'd0);
        set_win(1'b0, 2, 8'h10);
        step();
        check("wd2_idle_vld", 32'(vld), 32'd0);

        // Equal level, different id: hold.
        set_win(1'b1, 4, 8'h5F);
        arb_hv   = 1'b0;
        arb_mode = 1'b0;
        step();
        check("eq_vld", 32'(vld), 32'd1);
        set_win(1'b1, 6, 8'h5F);
        step();
        check("eq_hold_vld", 32'(vld), 32'd1);
        check("eq_hold_id", 32'(out_id), 32'd4);

        // Preemption by a higher-level winner.
        set_win(1'b1, 9, 8'hBF);
        step();
        check("pre_vld", 32'(vld), 32'd1);
`ifdef CLIC_PREEMPT_UPDATE_EN
        check("pre_id", 32'(out_id), 32'd9);
        check("pre_il", 32'(out_il), 32'hBF);
`else
        check("pre_id", 32'(out_id), 32'd4);
        check("pre_il", 32'(out_il), 32'h5F);
`endif
        ack = 1'b1;
        step();
        check("pre_claim", 32'(claim_vld), 32'd1);
`ifdef CLIC_PREEMPT_UPDATE_EN
        check("pre_claim_id", 32'(claim_id), 32'd9);
`else
        check("pre_claim_id", 32'(claim_id), 32'd4);
`endif
        check("pre_claim_vld_low", 32'(vld), 32'd0);
        ack = 1'b0;
        step();
        check("re_m2_vld", 32'(vld), 32'd0);
        check("re_m2_claim", 32'(claim_vld), 32'd0);
        step();
        check("re_m3_vld", 32'(vld), 32'd1);
        check("re_m3_id", 32'(out_id), 32'd9);

        // Same id: hv/mode refreshed.
        arb_hv   = 1'b1;
        arb_mode = 1'b1;
        step();
        check("same_id_hv_mode", 32'({out_hv, out_mode}), 32'd3);
        check("same_id_id", 32'(out_id), 32'd9);

        // Ack and req drop in the same cycle.
        ack = 1'b1;
        set_win(1'b0, 9, 8'hBF);
        step();
        check("sim_claim", 32'(claim_vld), 32'd1);
        check("sim_claim_id", 32'(claim_id), 32'd9);
        check("sim_vld", 32'(vld), 32'd0);
        ack = 1'b0;
        set_win(1'b1, 11, 8'h80);
        step();
        check("sim_m2_claim", 32'(claim_vld), 32'd0);
        check("sim_m2_vld", 32'(vld), 32'd0);
        step();
        check("sim_m3_vld", 32'(vld), 32'd1);
        check("sim_m3_id", 32'(out_id), 32'd11);

        // Reset during PEND, even with an ack in the same cycle.
        ack      = 1'b1;
        cpurst_b = 1'b0;
        step();
        check("rp_vld", 32'(vld), 32'd0);
        check("rp_id_il", 32'({out_id, out_il}), 32'd0);
        check("rp_claim", 32'({claim_vld, claim_id}), 32'd0);
        ack      = 1'b0;
        cpurst_b = 1'b1;
        step();
        check("rp_again_vld", 32'(vld), 32'd1);
        check("rp_again_claim", 32'(claim_vld), 32'd0);

        // Reset during CLAIM.
        ack = 1'b1;
        step();
        check("rc_claim_pre", 32'(claim_vld), 32'd1);
        ack      = 1'b0;
        cpurst_b = 1'b0;
        set_win(1'b0, 0, 0);
        step();
        check("rc_claim", 32'({claim_vld, claim_id}), 32'd0);
        check("rc_vld", 32'(vld), 32'd0);
        cpurst_b = 1'b1;
        step();
        check("rc_after_claim", 32'(claim_vld), 32'd0);
        check("rc_after_vld", 32'(vld), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
